kcpsmx_alu_seq: RTL and testbench
=================================

Name: kcpsmx_alu_seq

Overview:
- Multi-byte operation sequencer in front of the 8-bit KCPSMX ALU.
- Accepts one request covering 1..MAX_BYTES bytes. Each cycle it reads one operand byte pair from the register file, drives the ALU and writes the result byte back.
- Chains carry between bytes and folds per-byte flags into one zero/carry pair.
- Sits between the decode stage (requester) and the shared ALU/register-file ports.

Parameters:
- MAX_BYTES, 4, maximum operand length in bytes (power of two, 2..8).
- REG_ADDR_W, 4, register-file address width; register addresses wrap modulo 2**REG_ADDR_W.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  reset; synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_op  in  opcode_t  ADD, ADDCY, SUB, SUBCY, COMPARE, AND, OR, XOR, TEST, RS; any other code acts as pass-B.
- req_shift_op  in  shift_op_t  shift/rotate kind (RS only).
- req_shift_dir  in  1  0 = left, 1 = right.
- req_shift_const  in  1  shift constant.
- req_len  in  $clog2(MAX_BYTES)  byte count minus one.
- req_base_a, req_base_b, req_base_d  in  REG_ADDR_W each  LSB register address of operand A, operand B and destination.
- rf_addr_a, rf_addr_b  out  REG_ADDR_W each  register-file read addresses; read data is combinational.
- rf_data_a, rf_data_b  in  8 each  register-file read data.
- rf_wr_en  out  1  write strobe.
- rf_wr_addr  out  REG_ADDR_W  write address.
- rf_wr_data  out  8  write data.
- alu_operation  out  opcode_t  ALU operation.
- alu_shift_operation  out  shift_op_t  ALU shift kind.
- alu_shift_direction, alu_shift_constant, alu_carry_in  out  1 each  ALU controls.
- alu_operand_a, alu_operand_b  out  8 each  ALU operands.
- alu_result  in  8  ALU result.
- alu_zero, alu_carry  in  1 each  ALU flags.
- busy  out  1  high in EXEC and DONE.
- done  out  1  one-cycle pulse when flags are committed.
- flag_zero, flag_carry  out  1 each  architectural flags.

Behaviour:
- Reset values: state IDLE; req_ready 1; busy 0; done 0; rf_wr_en 0; flag_zero 0; flag_carry 0; byte index 0; ALU outputs 0.
- Reset mid-operation: abort immediately, issue no further writes; flags clear to 0.

State machine:
- IDLE: req_ready = 1. When req_valid, latch the request, set idx = 0 and go to EXEC.
- EXEC: process byte idx per cycle. After the byte where idx == len, go to DONE; otherwise idx++.
- DONE: commit flags, pulse done, return to IDLE. req_ready = 0 in EXEC and DONE.
- Latency: len + 2 cycles from acceptance to done. A new request can be accepted the cycle after done.

Byte order:
- Arithmetic, logic, pass-B and left shifts process LSB first: byte k = idx.
- Right shifts process MSB first: byte k = len − idx.
- Byte k uses addresses base_a + k, base_b + k and base_d + k, each modulo 2**REG_ADDR_W.
- rf_addr_* always track the current byte. alu_operand_* = rf_data_*.

Operation mapping, first byte:
- ADD → ADD, carry_in 0.
- ADDCY → ADDCY, carry_in flag_carry.
- SUB and COMPARE → SUB.
- SUBCY → SUBCY, carry_in flag_carry.
- RS → the requested shift_op.

Operation mapping, later bytes:
- ADD/ADDCY → ADDCY, carry_in = previous byte's alu_carry.
- SUB/SUBCY/COMPARE → SUBCY, carry_in = previous alu_carry.
- RS → SA, carry_in = previous alu_carry.
- Logic ops and pass-B keep the same op on every byte.

Writeback and flags:
- rf_wr_en = 1 in EXEC, except for COMPARE and TEST; rf_wr_data = alu_result.
- Zero accumulator: AND of all per-byte alu_zero.
- Carry: last byte's alu_carry. For TEST, carry is the XOR of all per-byte alu_carry (whole-word parity). AND/OR/XOR give carry 0.
- Flags update only in DONE; they are stable at all other times.
- Simultaneous reset and req_valid: reset wins and the request is not accepted.

Optional Feature:
- Macro: KCPSMX_ALU_SEQ_FLAG_SAVE_EN.
- When defined, add ports int_save in 1 and int_restore in 1, plus a one-entry shadow flag pair.
- int_save copies flag_zero/flag_carry into the shadow.
- int_restore loads the flags from the shadow next cycle; it is honoured only in IDLE and otherwise held off until IDLE.
- If a save and a DONE commit coincide, the shadow captures the newly committed flags.
- The shadow is reset to 0.
- When not defined, these ports and the shadow do not exist.

Test Plan:
- 2-byte ADD:
  - Setup: r0 = FF, r1 = 01, r2 = 01, r3 = 00; base_a = 0, base_b = 2, base_d = 4; len = 1.
  - Required: r4 = 00, r5 = 02; done 3 cycles after acceptance; zero 0, carry 0.
- 3-byte SUB of 000000 − 000001:
  - Required: destination = FF FF FF; carry 1, zero 0; second and third bytes driven as SUBCY with carry_in 1.
- 2-byte COMPARE of 1234 vs 1234:
  - Required: rf_wr_en never high; zero 1, carry 0.
  - Repeat with 1234 vs 1235: zero 0, carry 1.
- 2-byte SR0 of 8001:
  - Required: MSB address read first; result 4000; carry 1.
  - Then 2-byte TEST of 0301 & FFFF: no write; carry 1 (three set bits); zero 0.
- Abort and wrap:
  - Assert reset in the second EXEC cycle of a 4-byte ADD: exactly one write has occurred; flags 0; req_ready 1 next cycle.
  - base_d = F with len 1: writes go to F, then 0.
- With KCPSMX_ALU_SEQ_FLAG_SAVE_EN:
  - Sequence: flags Z = 1, C = 0 → int_save → run ADD giving Z = 0, C = 1 → int_restore.
  - Required: flags return to Z = 1, C = 0.

Source files
------------

// File: rtl/kcpsmx_alu_seq.sv
// Multi-byte operation sequencer in front of the 8-bit KCPSMX ALU.
// Optional interrupt flag save/restore is enabled by defining KCPSMX_ALU_SEQ_FLAG_SAVE_EN.
package kcpsmx_alu_seq_pkg;
  typedef enum logic [3:0] {
    OP_ADD     = 4'h0,
    OP_ADDCY   = 4'h1,
    OP_SUB     = 4'h2,
    OP_SUBCY   = 4'h3,
    OP_COMPARE = 4'h4,
    OP_AND     = 4'h5,
    OP_OR      = 4'h6,
    OP_XOR     = 4'h7,
    OP_TEST    = 4'h8,
    OP_RS      = 4'h9,
    OP_LOAD    = 4'hA
  } opcode_t;

  typedef enum logic [2:0] {
    SH_0   = 3'd0,
    SH_1   = 3'd1,
    SH_X   = 3'd2,
    SH_A   = 3'd3,
    SH_ROT = 3'd4
  } shift_op_t;
endpackage

module kcpsmx_alu_seq
  import kcpsmx_alu_seq_pkg::*;
#(
  parameter int MAX_BYTES  = 4,
  parameter int REG_ADDR_W = 4,
  localparam int LEN_W     = $clog2(MAX_BYTES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  opcode_t               req_op,
  input  shift_op_t             req_shift_op,
  input  logic                  req_shift_dir,
  input  logic                  req_shift_const,
  input  logic [LEN_W-1:0]      req_len,
  input  logic [REG_ADDR_W-1:0] req_base_a,
  input  logic [REG_ADDR_W-1:0] req_base_b,
  input  logic [REG_ADDR_W-1:0] req_base_d,
  output logic [REG_ADDR_W-1:0] rf_addr_a,
  output logic [REG_ADDR_W-1:0] rf_addr_b,
  input  logic [7:0]            rf_data_a,
  input  logic [7:0]            rf_data_b,
  output logic                  rf_wr_en,
  output logic [REG_ADDR_W-1:0] rf_wr_addr,
  output logic [7:0]            rf_wr_data,
  output opcode_t               alu_operation,
  output shift_op_t             alu_shift_operation,
  output logic                  alu_shift_direction,
  output logic                  alu_shift_constant,
  output logic                  alu_carry_in,
  output logic [7:0]            alu_operand_a,
  output logic [7:0]            alu_operand_b,
  input  logic [7:0]            alu_result,
  input  logic                  alu_zero,
  input  logic                  alu_carry,
  output logic                  busy,
  output logic                  done,
  output logic                  flag_zero,
  output logic                  flag_carry
`ifdef KCPSMX_ALU_SEQ_FLAG_SAVE_EN
 ,input  logic                  int_save,
  input  logic                  int_restore
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t                  state_q;
  opcode_t                 op_q;
  shift_op_t               shift_op_q;
  logic                    shift_dir_q;
  logic                    shift_const_q;
  logic [LEN_W-1:0]        len_q;
  logic [REG_ADDR_W-1:0]   base_a_q, base_b_q, base_d_q;
  logic [LEN_W-1:0]        idx_q;
  logic                    zacc_q, cacc_q;
  logic                    zacc_d, cacc_d;
  logic                    done_q;
  logic                    flag_zero_q, flag_carry_q;
  logic                    commit_carry;
  logic                    exec, first, last, right_shift, no_write, logic_op;
  logic [LEN_W-1:0]        k;
`ifdef KCPSMX_ALU_SEQ_FLAG_SAVE_EN
  logic                    shadow_zero_q, shadow_carry_q, restore_pend_q;
`endif

  always_comb begin
    exec        = (state_q == EXEC);
    first       = (idx_q == '0);
    last        = (idx_q == len_q);
    right_shift = (op_q == OP_RS) && shift_dir_q;
    no_write    = (op_q == OP_COMPARE) || (op_q == OP_TEST);
    logic_op    = (op_q == OP_AND) || (op_q == OP_OR) || (op_q == OP_XOR);
    k           = right_shift ? (len_q - idx_q) : idx_q;
  end

  // Byte operation and carry chaining: the first byte seeds the chain, later bytes ride on the previous carry.
  always_comb begin
    alu_operation       = OP_ADD;
    alu_shift_operation = SH_0;
    alu_carry_in        = 1'b0;
    if (exec) begin
      unique case (op_q)
        OP_ADD: begin
          alu_operation = first ? OP_ADD : OP_ADDCY;
          alu_carry_in  = first ? 1'b0 : cacc_q;
        end
        OP_ADDCY: begin
          alu_operation = OP_ADDCY;
          alu_carry_in  = first ? flag_carry_q : cacc_q;
        end
        OP_SUB, OP_COMPARE: begin
          alu_operation = first ? OP_SUB : OP_SUBCY;
          alu_carry_in  = first ? 1'b0 : cacc_q;
        end
        OP_SUBCY: begin
          alu_operation = OP_SUBCY;
          alu_carry_in  = first ? flag_carry_q : cacc_q;
        end
        OP_RS: begin
          alu_operation       = OP_RS;
          alu_shift_operation = first ? shift_op_q : SH_A;
          alu_carry_in        = first ? flag_carry_q : cacc_q;
        end
        default: alu_operation = op_q;
      endcase
    end
  end

  always_comb begin
    rf_addr_a           = base_a_q + REG_ADDR_W'(k);
    rf_addr_b           = base_b_q + REG_ADDR_W'(k);
    rf_wr_addr          = base_d_q + REG_ADDR_W'(k);
    rf_wr_data          = alu_result;
    rf_wr_en            = exec && !no_write && !reset;
    alu_operand_a       = exec ? rf_data_a : 8'h00;
    alu_operand_b       = exec ? rf_data_b : 8'h00;
    alu_shift_direction = exec && shift_dir_q;
    alu_shift_constant  = exec && shift_const_q;
    req_ready           = (state_q == IDLE);
    busy                = (state_q != IDLE);
    done                = done_q;
    flag_zero           = flag_zero_q;
    flag_carry          = flag_carry_q;
    // TEST folds carries into whole-word parity; everything else keeps the latest carry.
    zacc_d              = (first ? 1'b1 : zacc_q) & alu_zero;
    cacc_d              = ((op_q == OP_TEST) && !first) ? (cacc_q ^ alu_carry) : alu_carry;
    commit_carry        = logic_op ? 1'b0 : cacc_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      op_q          <= OP_ADD;
      shift_op_q    <= SH_0;
      shift_dir_q   <= 1'b0;
      shift_const_q <= 1'b0;
      len_q         <= '0;
      base_a_q      <= '0;
      base_b_q      <= '0;
      base_d_q      <= '0;
      idx_q         <= '0;
      zacc_q        <= 1'b0;
      cacc_q        <= 1'b0;
      done_q        <= 1'b0;
      flag_zero_q   <= 1'b0;
      flag_carry_q  <= 1'b0;
`ifdef KCPSMX_ALU_SEQ_FLAG_SAVE_EN
      shadow_zero_q  <= 1'b0;
      shadow_carry_q <= 1'b0;
      restore_pend_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            op_q          <= req_op;
            shift_op_q    <= req_shift_op;
            shift_dir_q   <= req_shift_dir;
            shift_const_q <= req_shift_const;
            len_q         <= req_len;
            base_a_q      <= req_base_a;
            base_b_q      <= req_base_b;
            base_d_q      <= req_base_d;
            idx_q         <= '0;
            state_q       <= EXEC;
          end
        end
        EXEC: begin
          zacc_q <= zacc_d;
          cacc_q <= cacc_d;
          if (last) begin
            state_q      <= DONE;
            done_q       <= 1'b1;
            flag_zero_q  <= zacc_d;
            flag_carry_q <= commit_carry;
          end else begin
            idx_q <= idx_q + LEN_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
`ifdef KCPSMX_ALU_SEQ_FLAG_SAVE_EN
      // A restore outside IDLE waits until the sequencer is idle again.
      if (state_q == IDLE) begin
        if (int_restore || restore_pend_q) begin
          flag_zero_q  <= shadow_zero_q;
          flag_carry_q <= shadow_carry_q;
        end
        restore_pend_q <= 1'b0;
      end else if (int_restore) begin
        restore_pend_q <= 1'b1;
      end
      if (int_save) begin
        if (exec && last) begin
          shadow_zero_q  <= zacc_d;
          shadow_carry_q <= commit_carry;
        end else begin
          shadow_zero_q  <= flag_zero_q;
          shadow_carry_q <= flag_carry_q;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_kcpsmx_alu_seq.sv
// Scoreboard bench for kcpsmx_alu_seq with a behavioural register file and ALU around it.
// Build with KCPSMX_ALU_SEQ_FLAG_SAVE_EN defined to also cover flag save/restore.
module tb_kcpsmx_alu_seq;
  import kcpsmx_alu_seq_pkg::*;

  localparam int LEN_W = 2;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
    logic [3:0] addrA;
    opcode_t    op;
    logic       chkCin;
    logic       cin;
    shift_op_t  shOp;
  } wrExp_t;

  logic            clk;
  logic            reset;
  logic            req_valid, req_ready;
  opcode_t         req_op;
  shift_op_t       req_shift_op;
  logic            req_shift_dir, req_shift_const;
  logic [LEN_W-1:0] req_len;
  logic [3:0]      req_base_a, req_base_b, req_base_d;
  logic [3:0]      rf_addr_a, rf_addr_b;
  logic [7:0]      rf_data_a, rf_data_b;
  logic            rf_wr_en;
  logic [3:0]      rf_wr_addr;
  logic [7:0]      rf_wr_data;
  opcode_t         alu_operation;
  shift_op_t       alu_shift_operation;
  logic            alu_shift_direction, alu_shift_constant, alu_carry_in;
  logic [7:0]      alu_operand_a, alu_operand_b;
  logic [7:0]      alu_result;
  logic            alu_zero, alu_carry;
  logic            busy, done, flag_zero, flag_carry;
`ifdef KCPSMX_ALU_SEQ_FLAG_SAVE_EN
  logic            intSave, intRestore;
`endif

  logic [7:0]      rf [16];
  logic            preEn;
  logic [3:0]      preAddr;
  logic [7:0]      preData;
  logic            shIn;

  wrExp_t          wrQ[$];
  logic [1:0]      flagQ[$];
  wrExp_t          wrE;
  logic [1:0]      flE;
  int              checkCount, errorCount, wrCount;

  kcpsmx_alu_seq #(.MAX_BYTES(4), .REG_ADDR_W(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_shift_op(req_shift_op), .req_shift_dir(req_shift_dir), .req_shift_const(req_shift_const),
    .req_len(req_len), .req_base_a(req_base_a), .req_base_b(req_base_b), .req_base_d(req_base_d),
    .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b), .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .alu_operation(alu_operation), .alu_shift_operation(alu_shift_operation),
    .alu_shift_direction(alu_shift_direction), .alu_shift_constant(alu_shift_constant),
    .alu_carry_in(alu_carry_in), .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .busy(busy), .done(done), .flag_zero(flag_zero), .flag_carry(flag_carry)
`ifdef KCPSMX_ALU_SEQ_FLAG_SAVE_EN
   ,.int_save(intSave), .int_restore(intRestore)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: combinational reads, writes on the rising edge; preload port used only while idle.
  assign rf_data_a = rf[rf_addr_a];
  assign rf_data_b = rf[rf_addr_b];
  always @(posedge clk) begin
    if (preEn) rf[preAddr] <= preData;
    else if (rf_wr_en) rf[rf_wr_addr] <= rf_wr_data;
  end

  // Reference 8-bit ALU; carry on subtraction is the borrow.
  always_comb begin
    alu_result = 8'h00;
    alu_carry  = 1'b0;
    shIn       = 1'b0;
    unique case (alu_operation)
      OP_ADD:   {alu_carry, alu_result} = {1'b0, alu_operand_a} + {1'b0, alu_operand_b};
      OP_ADDCY: {alu_carry, alu_result} = {1'b0, alu_operand_a} + {1'b0, alu_operand_b} + {8'h00, alu_carry_in};
      OP_SUB:   {alu_carry, alu_result} = {1'b0, alu_operand_a} - {1'b0, alu_operand_b};
      OP_SUBCY: {alu_carry, alu_result} = {1'b0, alu_operand_a} - {1'b0, alu_operand_b} - {8'h00, alu_carry_in};
      OP_AND:   alu_result = alu_operand_a & alu_operand_b;
      OP_OR:    alu_result = alu_operand_a | alu_operand_b;
      OP_XOR:   alu_result = alu_operand_a ^ alu_operand_b;
      OP_TEST: begin
        alu_result = alu_operand_a & alu_operand_b;
        alu_carry  = ^(alu_operand_a & alu_operand_b);
      end
      OP_RS: begin
        unique case (alu_shift_operation)
          SH_0:    shIn = 1'b0;
          SH_1:    shIn = 1'b1;
          SH_X:    shIn = alu_shift_direction ? alu_operand_a[7] : alu_operand_a[0];
          SH_A:    shIn = alu_carry_in;
          default: shIn = alu_shift_direction ? alu_operand_a[0] : alu_operand_a[7];
        endcase
        if (alu_shift_direction) begin
          alu_result = {shIn, alu_operand_a[7:1]};
          alu_carry  = alu_operand_a[0];
        end else begin
          alu_result = {alu_operand_a[6:0], shIn};
          alu_carry  = alu_operand_a[7];
        end
      end
      default:  alu_result = alu_operand_b;
    endcase
  end
  assign alu_zero = (alu_result == 8'h00);

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Scoreboard consumer: each write and each done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rf_wr_en) begin
      wrCount++;
      if (wrQ.size() == 0) begin
        checkOutput("unexpectedWrite", {31'd0, rf_wr_en}, 32'd0);
      end else begin
        wrE = wrQ.pop_front();
        checkOutput("wrAddr", {28'd0, rf_wr_addr}, {28'd0, wrE.addr});
        checkOutput("wrData", {24'd0, rf_wr_data}, {24'd0, wrE.data});
        checkOutput("rdAddrA", {28'd0, rf_addr_a}, {28'd0, wrE.addrA});
        checkOutput("aluOp", {28'd0, alu_operation}, {28'd0, wrE.op});
        if (wrE.chkCin) checkOutput("carryIn", {31'd0, alu_carry_in}, {31'd0, wrE.cin});
        if (wrE.op == OP_RS) checkOutput("shiftOp", {29'd0, alu_shift_operation}, {29'd0, wrE.shOp});
      end
    end
    if (done) begin
      if (flagQ.size() == 0) begin
        checkOutput("unexpectedDone", {31'd0, done}, 32'd0);
      end else begin
        flE = flagQ.pop_front();
        checkOutput("flagZero", {31'd0, flag_zero}, {31'd0, flE[1]});
        checkOutput("flagCarry", {31'd0, flag_carry}, {31'd0, flE[0]});
      end
    end
  end

  task automatic loadReg(input logic [3:0] a, input logic [7:0] d);
    preEn = 1'b1; preAddr = a; preData = d;
    @(posedge clk); #1;
    preEn = 1'b0;
  endtask

  task automatic pushWr(input logic [3:0] addr, input logic [7:0] data, input logic [3:0] addrA,
                        input opcode_t op, input logic chkCin, input logic cin, input shift_op_t shOp);
    wrExp_t e;
    e.addr = addr; e.data = data; e.addrA = addrA; e.op = op;
    e.chkCin = chkCin; e.cin = cin; e.shOp = shOp;
    wrQ.push_back(e);
  endtask

  task automatic driveReq(input opcode_t op, input shift_op_t sh, input logic dir, input logic [LEN_W-1:0] len,
                          input logic [3:0] ba, input logic [3:0] bb, input logic [3:0] bd);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) checkOutput("readyTimeout", {31'd0, req_ready}, 32'd1);
    req_op = op; req_shift_op = sh; req_shift_dir = dir; req_shift_const = 1'b0;
    req_len = len; req_base_a = ba; req_base_b = bb; req_base_d = bd;
    req_valid = 1'b1;
  endtask

  // Drives one request; lat counts cycles from the acceptance cycle (0) to the cycle done is high.
  task automatic applyStimulus(input opcode_t op, input shift_op_t sh, input logic dir, input logic [LEN_W-1:0] len,
                               input logic [3:0] ba, input logic [3:0] bb, input logic [3:0] bd, output int lat);
    driveReq(op, sh, dir, len, ba, bb, bd);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!done && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done) checkOutput("doneTimeout", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    int wrBefore;
    checkCount = 0; errorCount = 0; wrCount = 0;
    reset = 1'b1; req_valid = 1'b0; req_op = OP_ADD; req_shift_op = SH_0;
    req_shift_dir = 1'b0; req_shift_const = 1'b0; req_len = '0;
    req_base_a = '0; req_base_b = '0; req_base_d = '0;
    preEn = 1'b0; preAddr = '0; preData = '0;
`ifdef KCPSMX_ALU_SEQ_FLAG_SAVE_EN
    intSave = 1'b0; intRestore = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstReady", {31'd0, req_ready}, 32'd1);
    checkOutput("rstBusy", {31'd0, busy}, 32'd0);
    checkOutput("rstDone", {31'd0, done}, 32'd0);
    checkOutput("rstWrEn", {31'd0, rf_wr_en}, 32'd0);
    checkOutput("rstFlags", {30'd0, flag_zero, flag_carry}, 32'd0);
    checkOutput("rstAluOp", {28'd0, alu_operation}, 32'd0);
    checkOutput("rstAluCtl", {29'd0, alu_carry_in, alu_shift_direction, alu_shift_constant}, 32'd0);
    checkOutput("rstAluOpnd", {16'd0, alu_operand_a, alu_operand_b}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // 2-byte ADD 01FF + 0001 = 0200
    loadReg(4'h0, 8'hFF); loadReg(4'h1, 8'h01); loadReg(4'h2, 8'h01); loadReg(4'h3, 8'h00);
    pushWr(4'h4, 8'h00, 4'h0, OP_ADD, 1'b1, 1'b0, SH_0);
    pushWr(4'h5, 8'h02, 4'h1, OP_ADDCY, 1'b1, 1'b1, SH_0);
    flagQ.push_back(2'b00);
    applyStimulus(OP_ADD, SH_0, 1'b0, 2'd1, 4'h0, 4'h2, 4'h4, lat);
    checkOutput("addLatency", lat, 32'd3);
    checkOutput("addDrained", wrQ.size() + flagQ.size(), 32'd0);

    // 3-byte SUB 000000 - 000001 = FFFFFF with borrow
    loadReg(4'h6, 8'h00); loadReg(4'h7, 8'h00); loadReg(4'h8, 8'h00);
    loadReg(4'h9, 8'h01); loadReg(4'hA, 8'h00); loadReg(4'hB, 8'h00);
    pushWr(4'hC, 8'hFF, 4'h6, OP_SUB, 1'b1, 1'b0, SH_0);
    pushWr(4'hD, 8'hFF, 4'h7, OP_SUBCY, 1'b1, 1'b1, SH_0);
    pushWr(4'hE, 8'hFF, 4'h8, OP_SUBCY, 1'b1, 1'b1, SH_0);
    flagQ.push_back(2'b01);
    applyStimulus(OP_SUB, SH_0, 1'b0, 2'd2, 4'h6, 4'h9, 4'hC, lat);
    checkOutput("subLatency", lat, 32'd4);

    // COMPARE 1234 vs 1234, then 1234 vs 1235: no writes expected
    loadReg(4'h0, 8'h34); loadReg(4'h1, 8'h12); loadReg(4'h2, 8'h34); loadReg(4'h3, 8'h12);
    flagQ.push_back(2'b10);
    applyStimulus(OP_COMPARE, SH_0, 1'b0, 2'd1, 4'h0, 4'h2, 4'h4, lat);
    loadReg(4'h2, 8'h35);
    flagQ.push_back(2'b01);
    applyStimulus(OP_COMPARE, SH_0, 1'b0, 2'd1, 4'h0, 4'h2, 4'h4, lat);
    checkOutput("cmpFlagsHeld", {30'd0, flag_zero, flag_carry}, 32'd1);

    // 2-byte SR0 of 8001 = 4000, carry 1, MSB byte first
    loadReg(4'h0, 8'h01); loadReg(4'h1, 8'h80);
    pushWr(4'h5, 8'h40, 4'h1, OP_RS, 1'b0, 1'b0, SH_0);
    pushWr(4'h4, 8'h00, 4'h0, OP_RS, 1'b1, 1'b0, SH_A);
    flagQ.push_back(2'b01);
    applyStimulus(OP_RS, SH_0, 1'b1, 2'd1, 4'h0, 4'h0, 4'h4, lat);

    // TEST 0301 & FFFF: parity of three set bits
    loadReg(4'h0, 8'h01); loadReg(4'h1, 8'h03); loadReg(4'h2, 8'hFF); loadReg(4'h3, 8'hFF);
    flagQ.push_back(2'b01);
    applyStimulus(OP_TEST, SH_0, 1'b0, 2'd1, 4'h0, 4'h2, 4'h4, lat);

    // Abort a 4-byte ADD with reset in its second byte cycle
    loadReg(4'h0, 8'h01); loadReg(4'h4, 8'h10);
    pushWr(4'h8, 8'h11, 4'h0, OP_ADD, 1'b1, 1'b0, SH_0);
    wrBefore = wrCount;
    driveReq(OP_ADD, SH_0, 1'b0, 2'd3, 4'h0, 4'h4, 4'h8);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abortWrEn", {31'd0, rf_wr_en}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("abortWrites", wrCount - wrBefore, 32'd1);
    checkOutput("abortFlags", {30'd0, flag_zero, flag_carry}, 32'd0);
    checkOutput("abortReady", {30'd0, req_ready, busy}, 32'd2);
    @(posedge clk); #1;

    // Destination wrap: base_d = F, len 1 writes F then 0
    loadReg(4'h0, 8'h10); loadReg(4'h1, 8'h20); loadReg(4'h2, 8'h01); loadReg(4'h3, 8'h02);
    pushWr(4'hF, 8'h11, 4'h0, OP_ADD, 1'b1, 1'b0, SH_0);
    pushWr(4'h0, 8'h22, 4'h1, OP_ADDCY, 1'b1, 1'b0, SH_0);
    flagQ.push_back(2'b00);
    applyStimulus(OP_ADD, SH_0, 1'b0, 2'd1, 4'h0, 4'h2, 4'hF, lat);
    checkOutput("wrapDrained", wrQ.size() + flagQ.size(), 32'd0);

`ifdef KCPSMX_ALU_SEQ_FLAG_SAVE_EN
    // Save Z=1/C=0, clobber with an ADD, then restore
    loadReg(4'h0, 8'h34); loadReg(4'h1, 8'h12); loadReg(4'h2, 8'h34); loadReg(4'h3, 8'h12);
    flagQ.push_back(2'b10);
    applyStimulus(OP_COMPARE, SH_0, 1'b0, 2'd1, 4'h0, 4'h2, 4'h4, lat);
    intSave = 1'b1;
    @(posedge clk); #1;
    intSave = 1'b0;
    loadReg(4'h0, 8'hFF); loadReg(4'h1, 8'hFF); loadReg(4'h2, 8'h02); loadReg(4'h3, 8'h00);
    pushWr(4'h4, 8'h01, 4'h0, OP_ADD, 1'b1, 1'b0, SH_0);
    pushWr(4'h5, 8'h00, 4'h1, OP_ADDCY, 1'b1, 1'b1, SH_0);
    flagQ.push_back(2'b01);
    applyStimulus(OP_ADD, SH_0, 1'b0, 2'd1, 4'h0, 4'h2, 4'h4, lat);
    checkOutput("preRestore", {30'd0, flag_zero, flag_carry}, 32'd1);
    intRestore = 1'b1;
    @(posedge clk); #1;
    intRestore = 1'b0;
    @(negedge clk);
    checkOutput("restoredFlags", {30'd0, flag_zero, flag_carry}, 32'd2);
`endif

    repeat (2) @(posedge clk);
    checkOutput("queuesDrained", wrQ.size() + flagQ.size(), 32'd0);
    $display("[TB] Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
